// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: access width encoding, arbiter state
// and grant owner.
package mem_arb_pkg;

  // Access width, same encoding as the control unit's DataWidth.
  typedef enum logic [1:0] {
    WIDTH_WORD = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_BYTE = 2'b10
  } width_e;

  // Arbiter sequencing: wait for a request, run one memory access, ack.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Which requester owns the current access.
  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// lane_align: combinational byte-lane handling for data accesses.
// Stores get byte enables and lane-replicated write data; loads get the
// selected byte/half extracted and sign- or zero-extended; misaligned
// half/word accesses are flagged.
module lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic        we,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  // Bring the addressed lane down to bit 0 for extraction.
  assign shifted = rdata >> {offset, 3'b000};

  // Per-width enables, replication, extension and alignment check.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    misalign  = 1'b0;
    case (width)
      WIDTH_BYTE: begin
        if (we) begin
          be        = 4'b0001 << offset;
          wdata_rep = {4{wdata[7:0]}};
        end
        rdata_ext = {{24{shifted[7] & ~zero_ext}}, shifted[7:0]};
      end
      WIDTH_HALF: begin
        misalign = offset[0];
        if (we) begin
          be        = 4'b0011 << offset;
          wdata_rep = {2{wdata[15:0]}};
        end
        rdata_ext = {{16{shifted[15] & ~zero_ext}}, shifted[15:0]};
      end
      default: begin
        // Word (the unused encoding 11 is treated as a word too).
        misalign = |offset;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and
// load/store. Requests are evaluated only in IDLE; an access runs in BUSY
// until mem_ready, then the owner's ack pulses for the single DONE cycle.
// Misaligned data requests skip memory and go straight to DONE.
// Build option MEM_ARB_RR_EN: round-robin between simultaneous requests
// instead of fixed data-first priority.
//
// Handshake: a requester raises *_req with its inputs stable and keeps them
// so until its *_ack pulse; the memory sees mem_en with address/controls
// stable and completes on the cycle mem_ready is high.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [1:0]            d_width,
  input  logic                  d_unsigned,
  output logic [31:0]           d_rdata,
  output logic                  d_ack,
  output logic                  d_misalign,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  stall,
  output logic [1:0]            dbg_state
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;

  logic        pick_data;
  logic        load_req;
  logic        take_misalign;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_we_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_be_q;
  logic [31:0]           if_rdata_q;
  logic [31:0]           d_rdata_q;
  logic                  misalign_q;

  // Fetch addresses are word aligned by contract; the low bits are dropped.
  logic unused_if_lsb;
  assign unused_if_lsb = ^if_addr[1:0];

  lane_align u_lane_align (
    .width     (d_width),
    .offset    (d_addr[1:0]),
    .we        (d_we),
    .zero_ext  (d_unsigned),
    .wdata     (d_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  // On a tie, serve whoever was not granted last.
  assign pick_data = d_req & (~if_req | (last_q == OWN_FETCH));

  // Remember the most recent grant; reset favours data on the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= OWN_FETCH;
    end else if (state_q == IDLE && (d_req || if_req)) begin
      last_q <= owner_d;
    end
  end
`else
  // Fixed priority: data always wins a tie.
  assign pick_data = d_req;
`endif

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_DATA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic and grant decision.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    load_req      = 1'b0;
    take_misalign = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          owner_d = pick_data ? OWN_DATA : OWN_FETCH;
          if (pick_data && al_misalign) begin
            state_d       = DONE;
            take_misalign = 1'b1;
          end else begin
            state_d  = BUSY;
            load_req = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch memory controls at grant and capture read data on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      if (load_req) begin
        if (owner_d == OWN_DATA) begin
          mem_addr_q  <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_we_q    <= d_we;
          mem_wdata_q <= al_wdata;
          mem_be_q    <= al_be;
        end else begin
          mem_addr_q  <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_we_q    <= 1'b0;
          mem_wdata_q <= '0;
          mem_be_q    <= 4'b1111;
        end
      end
      if (state_q == IDLE) begin
        misalign_q <= take_misalign;
      end
      if (take_misalign) begin
        d_rdata_q <= '0;
      end
      if (state_q == BUSY && mem_ready) begin
        if (owner_q == OWN_DATA) begin
          d_rdata_q <= d_we ? 32'h0 : al_rdata;
        end else begin
          if_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_en     = (state_q == BUSY);
  assign mem_we     = mem_we_q & (state_q == BUSY);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign if_ack     = (state_q == DONE) && (owner_q == OWN_FETCH);
  assign d_ack      = (state_q == DONE) && (owner_q == OWN_DATA);
  assign d_misalign = d_ack & misalign_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign stall      = (if_req & ~if_ack) | (d_req & ~d_ack);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vectors, scoreboard of expected acks
// checked by an independent monitor, plus inline checks of memory-side
// controls, latency and reset behaviour.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int W  = 35; // {check_rdata, is_data, misalign, rdata}

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [1:0]    d_width;
  logic          d_unsigned;
  logic [31:0]   d_rdata;
  logic          d_ack;
  logic          d_misalign;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          stall;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  // Memory responder settings.
  int          ready_delay = 0;
  int          busy_cnt    = 0;
  logic [31:0] rdata_val   = 32'h0;

  // Values captured by the data-access driver.
  int          cyc;
  bit          saw_en;
  bit          addr_ok;
  bit          stall_ok;
  bit          stall_at_ack;
  logic [AW-1:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        cap_we;

  mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_width    (d_width),
    .d_unsigned (d_unsigned),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .d_misalign (d_misalign),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  assign mem_rdata = rdata_val;

  // Complete the access after ready_delay cycles of mem_en.
  always @(negedge clk) begin
    if (mem_en) begin
      mem_ready = (busy_cnt >= ready_delay);
      busy_cnt  = busy_cnt + 1;
    end else begin
      mem_ready = 1'b0;
      busy_cnt  = 0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit chk, input bit is_data, input bit mis, input logic [31:0] rd);
    exp_q.push_back({chk, is_data, mis, rd});
  endtask

  // Monitor: every ack pops one expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [31:0]  act_rd;
    if (rst_n && (d_ack || if_ack)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {d_ack, if_ack}, 0);
      end else begin
        e      = exp_q.pop_front();
        act_rd = d_ack ? d_rdata : if_rdata;
        check("ack_response",
              {d_ack, d_ack & d_misalign, e[34] ? act_rd : 32'h0},
              {e[33], e[32], e[34] ? e[31:0] : 32'h0});
      end
    end
  end

  task automatic check_reset_state();
    check("rst_state", dbg_state, 2'd0);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_d_misalign", d_misalign, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_stall", stall, 0);
  endtask

  // ---------------- drivers ----------------
  // One data access; cyc = cycles from request-seen edge to ack.
  task automatic data_access(input bit we, input logic [AW-1:0] addr,
                             input logic [31:0] wdata, input logic [1:0] width,
                             input bit uns);
    bit got;
    repeat (2) @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    d_width = width; d_unsigned = uns;
    cyc = 0; saw_en = 0; addr_ok = 1; stall_ok = 1; stall_at_ack = 1; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_en) begin
        if (!saw_en) begin
          cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
        end else if (mem_addr !== cap_addr) begin
          addr_ok = 0;
        end
        saw_en = 1;
      end
      if (d_ack) begin
        got = 1;
        stall_at_ack = stall;
      end else if (!stall) begin
        stall_ok = 0;
      end
    end
    d_req = 1'b0; d_we = 1'b0;
    if (!got) check("data_ack_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d_left;
    int f_left;
    rst_n = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_width = 2'b00; d_unsigned = 0; mem_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;

    // Load byte, sign-extended, minimum latency.
    rdata_val = 32'h80FF_FFFF; ready_delay = 0;
    push_exp(1, 1, 0, 32'hFFFF_FF80);
    data_access(0, 32'h103, 32'h0, 2'b10, 0);
    check("ldb_latency", cyc, 2);
    check("ldb_mem_addr", cap_addr, 32'h100);
    check("ldb_mem_be", cap_be, 4'b1111);
    check("ldb_mem_we", cap_we, 0);

    // Store half at offset 2.
    push_exp(0, 1, 0, 32'h0);
    data_access(1, 32'h202, 32'h0000_1234, 2'b01, 0);
    check("sth_mem_be", cap_be, 4'b1100);
    check("sth_mem_wdata", cap_wdata, 32'h1234_1234);
    check("sth_mem_addr", cap_addr, 32'h200);
    check("sth_mem_we", cap_we, 1);
    check("sth_latency", cyc, 2);

    // Load half unsigned at offset 2.
    rdata_val = 32'hBEEF_0123;
    push_exp(1, 1, 0, 32'h0000_BEEF);
    data_access(0, 32'h206, 32'h0, 2'b01, 1);

    // Store byte at offset 1.
    push_exp(0, 1, 0, 32'h0);
    data_access(1, 32'h301, 32'h0000_00A5, 2'b10, 0);
    check("stb_mem_be", cap_be, 4'b0010);
    check("stb_mem_wdata", cap_wdata, 32'hA5A5_A5A5);

    // Misaligned word load.
    push_exp(1, 1, 1, 32'h0);
    data_access(0, 32'h101, 32'h0, 2'b00, 0);
    check("mis_latency", cyc, 1);
    check("mis_mem_en_seen", saw_en, 0);

    // Wait states.
    rdata_val = 32'h1357_9BDF; ready_delay = 3;
    push_exp(1, 1, 0, 32'h1357_9BDF);
    data_access(0, 32'h500, 32'h0, 2'b00, 0);
    check("wait_latency", cyc, 5);
    check("wait_addr_stable", addr_ok, 1);
    check("wait_mem_addr", cap_addr, 32'h500);
    check("wait_stall_before_ack", stall_ok, 1);
    check("wait_stall_at_ack", stall_at_ack, 0);

    // Reset during BUSY abandons the access.
    ready_delay = 10;
    repeat (2) @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h600; d_width = 2'b00; d_unsigned = 0;
    @(posedge clk); #1;
    check("abort_busy_en", mem_en, 1);
    @(negedge clk);
    rst_n = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state();
    begin
      int en_cnt;
      en_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (mem_en) en_cnt++;
      end
      check("abort_mem_en_after", en_cnt, 0);
    end

    // Simultaneous requests; data re-requests right after its first ack.
    ready_delay = 0; rdata_val = 32'h1122_3344;
`ifdef MEM_ARB_RR_EN
    push_exp(1, 1, 0, 32'h1122_3344);
    push_exp(1, 0, 0, 32'h1122_3344);
    push_exp(1, 1, 0, 32'h1122_3344);
`else
    push_exp(1, 1, 0, 32'h1122_3344);
    push_exp(1, 1, 0, 32'h1122_3344);
    push_exp(1, 0, 0, 32'h1122_3344);
`endif
    repeat (2) @(negedge clk);
    d_we = 0; d_width = 2'b00; d_unsigned = 0; d_addr = 32'h300; if_addr = 32'h400;
    d_req = 1; if_req = 1;
    d_left = 2; f_left = 1;
    for (int i = 0; i < 60 && (d_left > 0 || f_left > 0); i++) begin
      @(posedge clk); #1;
      if (mem_en && mem_addr == 32'h400) begin
        check("fetch_mem_be", mem_be, 4'b1111);
        check("fetch_mem_we", mem_we, 0);
      end
      if (d_ack) begin
        d_left--;
        if (d_left == 0) d_req = 0;
      end
      if (if_ack) begin
        f_left--;
        if_req = 0;
      end
    end
    check("tie_all_served", {d_left[3:0], f_left[3:0]}, 0);

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
